pc_predict: RTL and testbench

- Fetch-side PC generator and branch predictor; the initiator at the other end of the decoder's `isTaken` / `branch_flag` / `branch_addr` interface.
- Drives the fetch address each cycle and predecodes the fetched instruction for BNE.
- Predicts the branch direction from a table of 2-bit saturating counters and tags each fetch with the prediction.
- Accepts decode-stage redirects on misprediction and decode-stage training updates. Sits between CTRL/ID and the instruction ROM / IF-ID register.

---
 rtl/pc_predict_pkg.sv | 35 +++
 rtl/pc_bht.sv | 35 +++
 rtl/pc_predict.sv | 86 ++++++++
 tb/tb_pc_predict.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_predict_pkg.sv
// Shared constants, counter encodings and the saturating-counter helper for the
// fetch-side PC generator and branch history table.
package pc_predict_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned OPCODE_W    = 6;
  localparam int unsigned CTR_W       = 2;

  localparam logic [OPCODE_W-1:0] EXE_BNE = 6'b000101;

  // Saturating 2-bit direction counter; MSB is the taken prediction.
  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int unsigned      BHT_IDX_W_DFLT = 6;
  localparam logic [CTR_W-1:0] BHT_INIT_DFLT  = CTR_WNT;

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] cur,
                                                input logic taken);
    logic [CTR_W-1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + CTR_W'(1);
    end else begin
      if (cur != CTR_SNT) nxt = cur - CTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read port
// and one synchronous update port; no read-during-write bypass.
module pc_bht
  import pc_predict_pkg::*;
#(
  parameter int unsigned      IDX_W = BHT_IDX_W_DFLT,
  parameter logic [CTR_W-1:0] INIT  = BHT_INIT_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr_c,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] ctr [DEPTH];

  // Prediction sees the pre-update value when read and update collide.
  assign rd_ctr_c = ctr[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr[IDX_W'(i)] <= INIT;
      end
    end else if (upd_valid) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC generator with BNE predecode and counter-table direction prediction.
// The predictor is built only when PC_BRANCH_PREDICT_EN is defined.
module pc_predict
  import pc_predict_pkg::*;
#(
  parameter int unsigned      BHT_IDX_W = BHT_IDX_W_DFLT,
  parameter logic [CTR_W-1:0] BHT_INIT  = BHT_INIT_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_stall,
  input  logic [INST_W-1:0]      input_inst,
  input  logic                   input_branch_flag,
  input  logic [INST_ADDR_W-1:0] input_branch_addr,
  input  logic                   input_upd_valid,
  input  logic [INST_ADDR_W-1:0] input_upd_pc,
  input  logic                   input_upd_taken,
  output logic [INST_ADDR_W-1:0] output_pc,
  output logic                   output_ce,
  output logic                   output_isTaken
);

  logic                   taken_c;
  logic [INST_ADDR_W-1:0] next_pc_c;

`ifdef PC_BRANCH_PREDICT_EN
  logic                   is_bne_c;
  logic [INST_ADDR_W-1:0] target_c;
  logic [CTR_W-1:0]       rd_ctr_c;
  logic [BHT_IDX_W-1:0]   rd_idx_c;
  logic [BHT_IDX_W-1:0]   upd_idx_c;
  logic                   unused_bits;

  // Target arithmetic matches the decoder's BNE target exactly.
  assign is_bne_c  = (input_inst[31:26] == EXE_BNE);
  assign target_c  = output_pc + INST_ADDR_W'(4)
                   + {{14{input_inst[15]}}, input_inst[15:0], 2'b00};
  assign rd_idx_c  = output_pc[BHT_IDX_W+1:2];
  assign upd_idx_c = input_upd_pc[BHT_IDX_W+1:2];

  pc_bht #(
    .IDX_W (BHT_IDX_W),
    .INIT  (BHT_INIT)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx_c),
    .rd_ctr_c  (rd_ctr_c),
    .upd_valid (input_upd_valid),
    .upd_idx   (upd_idx_c),
    .upd_taken (input_upd_taken)
  );

  assign taken_c     = output_ce & is_bne_c & rd_ctr_c[1];
  assign unused_bits = ^{input_inst[25:16], input_upd_pc};
`else
  logic unused_bits;

  assign taken_c     = 1'b0;
  assign unused_bits = ^{input_inst, input_upd_valid, input_upd_pc, input_upd_taken};
`endif

  assign output_isTaken = taken_c;

  // Redirect outranks prediction, which outranks sequential fetch.
  always_comb begin
    next_pc_c = output_pc + INST_ADDR_W'(4);
`ifdef PC_BRANCH_PREDICT_EN
    if (taken_c) next_pc_c = target_c;
`endif
    if (input_branch_flag) next_pc_c = input_branch_addr;
  end

  // First cycle out of reset only raises ce; PC starts moving the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_pc <= '0;
      output_ce <= 1'b0;
    end else if (!output_ce) begin
      output_ce <= 1'b1;
    end else if (!input_stall) begin
      output_pc <= next_pc_c;
    end
  end

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict; predictor checks follow PC_BRANCH_PREDICT_EN.
module tb_pc_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] inst;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] pc;
  logic        ce;
  logic        is_taken;

  logic [31:0] bne_pc;
  logic [15:0] bne_imm;
  logic [31:0] pc_after_bne;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // ROM: a single BNE at bne_pc, zeros elsewhere.
  always_comb inst = (pc == bne_pc) ? {6'b000101, 5'd1, 5'd2, bne_imm} : 32'h0;

  pc_predict dut (
    .clk               (clk),
    .rst               (rst),
    .input_stall       (stall),
    .input_inst        (inst),
    .input_branch_flag (branch_flag),
    .input_branch_addr (branch_addr),
    .input_upd_valid   (upd_valid),
    .input_upd_pc      (upd_pc),
    .input_upd_taken   (upd_taken),
    .output_pc         (pc),
    .output_ce         (ce),
    .output_isTaken    (is_taken)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Train the entry of upd_addr once while the PC is held by stall.
  task automatic train(input logic [31:0] upd_addr, input logic t);
    upd_valid = 1'b1;
    upd_pc    = upd_addr;
    upd_taken = t;
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_addr = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    bne_pc = 32'h10; bne_imm = 16'h0004;

    // Reset hold and release.
    repeat (3) begin
      step();
      chk("rst_ce", 32'(ce), 32'h0);
      chk("rst_pc", pc, 32'h0);
    end
    rst = 1'b0;
    step();
    chk("rel1_ce", 32'(ce), 32'h1);
    chk("rel1_pc", pc, 32'h0);
    train(32'h10, 1'b1);  // counter of 0x10 WNT -> WT
    chk("rel2_pc", pc, 32'h4);
    step();
    chk("rel3_pc", pc, 32'h8);
    step();
    chk("seq_pc_c", pc, 32'hC);
    step();
    chk("seq_pc_10", pc, 32'h10);
`ifdef PC_BRANCH_PREDICT_EN
    chk("bne_taken", 32'(is_taken), 32'h1);
    pc_after_bne = 32'h24;
`else
    chk("bne_taken_off", 32'(is_taken), 32'h0);
    pc_after_bne = 32'h14;
`endif
    step();
    chk("bne_next_pc", pc, pc_after_bne);

    // Redirect is dropped under stall, taken otherwise.
    branch_flag = 1'b1; branch_addr = 32'h40; stall = 1'b1;
    step();
    chk("stall_redir_pc", pc, pc_after_bne);
    stall = 1'b0;
    step();
    chk("redir_pc", pc, 32'h40);
    branch_addr = 32'hFFFF_FFFC;
    step();
    branch_flag = 1'b0;
    chk("redir_top_pc", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);

    // Mid-stream reset overrides redirect and update.
    rst = 1'b1; branch_flag = 1'b1; branch_addr = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
    step();
    chk("mrst_ce", 32'(ce), 32'h0);
    chk("mrst_pc", pc, 32'h0);
    rst = 1'b0; branch_flag = 1'b0; upd_valid = 1'b0;
    step();
    chk("mrst_rel_ce", 32'(ce), 32'h1);
    chk("mrst_rel_pc", pc, 32'h0);

    // Park on 0x10 with stall held.
    branch_flag = 1'b1; branch_addr = 32'h10;
    step();
    branch_flag = 1'b0; stall = 1'b1;
    chk("park_pc", pc, 32'h10);

`ifdef PC_BRANCH_PREDICT_EN
    chk("rst_ctr_nt", 32'(is_taken), 32'h0);
    // Five taken: 01->10->11->11->11->11.
    for (int i = 0; i < 5; i++) begin
      train(32'h10, 1'b1);
      chk("sat_up_taken", 32'(is_taken), 32'h1);
    end
    chk("stall_hold_pc", pc, 32'h10);
    train(32'h10, 1'b0);  // 11 -> 10
    chk("dn1_taken", 32'(is_taken), 32'h1);
    train(32'h10, 1'b0);  // 10 -> 01
    chk("dn2_taken", 32'(is_taken), 32'h0);
    train(32'h10, 1'b0);  // 01 -> 00
    train(32'h10, 1'b0);  // 00 stays
    train(32'h10, 1'b1);  // 00 -> 01
    chk("sat_lo_taken", 32'(is_taken), 32'h0);
    train(32'h10, 1'b1);  // 01 -> 10
    chk("wt_taken", 32'(is_taken), 32'h1);

    // Collision: pre-update value drives this cycle's prediction.
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0;
    #1;
    chk("coll_same_cycle", 32'(is_taken), 32'h1);
    step();
    upd_valid = 1'b0;
    chk("coll_next_cycle", 32'(is_taken), 32'h0);
    train(32'h10, 1'b1);  // back to WT

    // Redirect outranks a taken prediction.
    chk("prio_pred", 32'(is_taken), 32'h1);
    stall = 1'b0; branch_flag = 1'b1; branch_addr = 32'h80;
    step();
    branch_flag = 1'b0; stall = 1'b1;
    chk("prio_redir_pc", pc, 32'h80);

    // Backward BNE at 0x80: target 0x80 + 4 - 32 = 0x64.
    bne_pc = 32'h80; bne_imm = 16'hFFF8;
    #1;
    chk("bwd_init_nt", 32'(is_taken), 32'h0);
    train(32'h80, 1'b1);
    chk("bwd_taken", 32'(is_taken), 32'h1);
    stall = 1'b0;
    step();
    chk("bwd_target_pc", pc, 32'h64);
`else
    for (int i = 0; i < 3; i++) begin
      train(32'h10, 1'b1);
      chk("off_taken", 32'(is_taken), 32'h0);
    end
    chk("off_hold_pc", pc, 32'h10);
    stall = 1'b0;
    step();
    chk("off_seq_pc", pc, 32'h14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
